dna_port_responder: RTL and testbench
=====================================

// Module: dna_port_responder
// PURPOSE
//  Synthesisable stand-in for the DNA_PORT primitive: the device side of the serial DNA interface.
//  - READ loads a stored 57-bit ID into a shift register.
//  - SHIFT clocks the ID out MSB-first on dout, with din entering at the LSB.
//  Used in simulation benches and in builds where the primitive is absent.
//  Also tracks the shift count and flags protocol misuse by the capture side.
// PARAMETERS
//  DNA_WIDTH  57            ID length in bits
//  DNA_INIT   57'h1_2345_6789_ABCD_EF  stored ID after reset
//  CNT_W      8             width of bits_shifted; count saturates at 2^CNT_W-1
// PORTS
//  sys_clk       in   1          single clock, all logic on rising edge
//  sys_rst       in   1          asynchronous, active-high reset
//  cfg_dna       in   DNA_WIDTH  new ID value
//  cfg_load      in   1          write cfg_dna into the stored ID; accepted only when cfg_ready=1
//  cfg_ready     out  1          high when not in SHIFTING
//  read          in   1          load the shift register from the stored ID (priority over shift)
//  shift         in   1          shift the register one place toward the MSB
//  din           in   1          serial input into bit 0
//  dout          out  1          shift-register MSB
//  bits_shifted  out  CNT_W      shifts since the last read (saturating)
//  frame_done    out  1          1-cycle pulse when the 57th shift after a read completes
//  err_no_load   out  1          sticky: shift seen in IDLE
//  err_overshift out  1          sticky: shift seen in EXHAUSTED
//  err_read_mid  out  1          sticky: read seen in SHIFTING
//  err_clr       in   1          synchronous clear of all sticky errors; a new error in the same cycle wins
// BEHAVIOUR
//  Reset values:
//  - sreg=0, stored ID=DNA_INIT, state=IDLE.
//  - dout=0, bits_shifted=0, frame_done=0, all err_*=0, cfg_ready=1.
//  dout is sreg[DNA_WIDTH-1] and is registered, with no extra stage.
//  - After a read at edge N, dout shows ID[56] from edge N onward.
//  - Each shift edge presents the next lower bit.
//  - A capture side sampling dout on the same edge as shift therefore receives ID[56] first.
//  Read at an edge:
//  - sreg <= stored ID; bits_shifted <= 0; state <= LOADED.
//  - shift is ignored in that cycle.
//  Shift with read=0:
//  - sreg <= {sreg[DNA_WIDTH-2:0], din}; bits_shifted increments, saturating.
//  Cycle with neither read nor shift: sreg and bits_shifted hold.
//  States:
//  - IDLE: no read since reset. shift still shifts (zeros, then din) and sets err_no_load; state stays IDLE.
//  - LOADED: read seen, bits_shifted=0. shift -> SHIFTING. read -> LOADED.
//  - SHIFTING: 0<bits_shifted<57. Shift #57 -> EXHAUSTED and frame_done=1 in the following cycle.
//    read -> LOADED and sets err_read_mid.
//  - EXHAUSTED: all ID bits delivered. shift keeps shifting, so din bits reappear on dout after 57 shifts,
//    and sets err_overshift. read -> LOADED.
//  cfg_load:
//  - With cfg_ready=1, the stored ID <= cfg_dna at that edge. With cfg_ready=0, ignored and the stored ID is unchanged.
//  - The current sreg is never affected by cfg_load.
//  - cfg_load together with read in the same cycle: read loads the OLD stored ID; the new ID applies from the next read.
//  Sync reset on read:
//  - frame_done never pulses twice per read.
//  - A read in the same cycle as shift #57 cancels that shift, so there is no pulse.
//  Reset asserted mid-shift:
//  - Everything returns to reset values immediately (async).
//  - A cfg-loaded ID is lost and the stored ID reverts to DNA_INIT.
//  Widths: bits_shifted is compared against DNA_WIDTH at CNT_W bits; CNT_W must be >= clog2(DNA_WIDTH+1).
// TESTING
//  T1: pulse sys_rst mid-run -> all outputs at reset values; cfg_ready=1; first read then yields DNA_INIT.
//  T2: read 1 cycle, then shift 57 cycles with din=0, sampling dout each shift edge
//      -> bits 57'h1_2345_6789_ABCD_EF MSB-first; frame_done exactly one pulse; bits_shifted=57; no errors.
//  T3: after T2, shift 60 more cycles with din=1
//      -> err_overshift=1; dout reads 57 zeros then ones; bits_shifted=117.
//      Then err_clr -> err_overshift=0.
//  T4: shift 5 cycles before any read -> err_no_load=1; dout=0 throughout.
//      read+shift in the same cycle -> LOADED, bits_shifted=0, dout=ID[56].
//  T5: during SHIFTING, cfg_load with 57'h0_FFFF_0000_FFFF_00 -> ignored; cfg_ready=0.
//      Then read -> err_read_mid=1 and the old ID restarts.
//      cfg_load in LOADED, then read -> the new ID is shifted out.
//  T6: assert sys_rst after 30 shifts -> immediate reset; frame_done never pulses; the stored ID reverts to DNA_INIT.

Source files
------------

// File: rtl/dna_port_responder.sv
// Device side of the serial DNA interface: a loadable 57-bit ID shifted out MSB-first,
// with a shift counter, end-of-frame pulse and sticky protocol-misuse flags.
module dna_port_responder #(
   parameter int unsigned             DNA_WIDTH = 57,
   parameter logic [DNA_WIDTH-1:0]    DNA_INIT  = 57'h1_2345_6789_ABCD_EF,
   parameter int unsigned             CNT_W     = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [DNA_WIDTH-1:0] cfg_dna,
   input  logic                 cfg_load,
   output logic                 cfg_ready,
   input  logic                 read,
   input  logic                 shift,
   input  logic                 din,
   output logic                 dout,
   output logic [CNT_W-1:0]     bits_shifted,
   output logic                 frame_done,
   output logic                 err_no_load,
   output logic                 err_overshift,
   output logic                 err_read_mid,
   input  logic                 err_clr
);

   typedef enum logic [1:0] {StIdle, StLoaded, StShifting, StExhausted} state_e;

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DNA_WIDTH);

   state_e               state_q, state_d;
   logic [DNA_WIDTH-1:0] sreg_q, sreg_d;
   logic [DNA_WIDTH-1:0] id_q, id_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 frame_done_q, frame_done_d;
   // [0] no_load, [1] overshift, [2] read_mid
   logic [2:0]           err_q, err_d;
   logic [2:0]           err_set;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= StIdle;
         sreg_q       <= '0;
         id_q         <= DNA_INIT;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      err_set      = '0;

      // The shift register only ever sees the stored ID registered before this edge.
      if (cfg_load && cfg_ready) begin
         id_d = cfg_dna;
      end

      if (read) begin
         sreg_d     = id_q;
         cnt_d      = '0;
         state_d    = StLoaded;
         err_set[2] = (state_q == StShifting);
      end else if (shift) begin
         sreg_d = {sreg_q[DNA_WIDTH-2:0], din};
         if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
         end
         unique case (state_q)
            StIdle: err_set[0] = 1'b1;
            StLoaded, StShifting: begin
               if (cnt_d == LastCnt) begin
                  state_d      = StExhausted;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = StShifting;
               end
            end
            StExhausted: err_set[1] = 1'b1;
            default: state_d = StIdle;
         endcase
      end

      err_d = (err_q & ~{3{err_clr}}) | err_set;
   end

   always_comb begin
      cfg_ready     = (state_q != StShifting);
      dout          = sreg_q[DNA_WIDTH-1];
      bits_shifted  = cnt_q;
      frame_done    = frame_done_q;
      err_no_load   = err_q[0];
      err_overshift = err_q[1];
      err_read_mid  = err_q[2];
   end

endmodule

// File: tb/tb_dna_port_responder.sv
// Scenario bench for dna_port_responder: expected dout bits are queued when a read or
// shift sequence is set up and popped as the DUT presents each bit.
module tb_dna_port_responder;

   localparam int unsigned W = 57;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [W-1:0]  cfg_dna = '0;
   logic          cfg_load = 1'b0;
   logic          cfg_ready;
   logic          read = 1'b0;
   logic          shift = 1'b0;
   logic          din = 1'b0;
   logic          dout;
   logic [7:0]    bits_shifted;
   logic          frame_done;
   logic          err_no_load;
   logic          err_overshift;
   logic          err_read_mid;
   logic          err_clr = 1'b0;

   logic [W-1:0]  id_init = 57'h1_2345_6789_ABCD_EF;
   logic [W-1:0]  id_new  = 57'h0_FFFF_0000_FFFF_00;

   logic          exp_q[$];
   logic          exp_bit;
   int            n_cmp = 0;
   int            n_err = 0;
   int            fd_count = 0;
   int            fd_base;

   dna_port_responder dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .cfg_dna       (cfg_dna),
      .cfg_load      (cfg_load),
      .cfg_ready     (cfg_ready),
      .read          (read),
      .shift         (shift),
      .din           (din),
      .dout          (dout),
      .bits_shifted  (bits_shifted),
      .frame_done    (frame_done),
      .err_no_load   (err_no_load),
      .err_overshift (err_overshift),
      .err_read_mid  (err_read_mid),
      .err_clr       (err_clr)
   );

   always #5 sys_clk = ~sys_clk;

   // frame_done lasts one full cycle, so each pulse is seen at exactly one falling edge.
   always @(negedge sys_clk) if (frame_done === 1'b1) fd_count++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_id(input logic [W-1:0] id);
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(id[i]);
   endtask

   task automatic test_reset;
      read = 1'b1; tick; read = 1'b0;
      shift = 1'b1; repeat (3) tick; shift = 1'b0;
      read = 1'b1; tick; read = 1'b0;
      #2 sys_rst = 1'b1;
      #1;
      n_cmp++; if (dout !== 1'b0) begin n_err++; $display("FAIL t1_dout: got %b want 0", dout); end
      n_cmp++; if (bits_shifted !== 8'd0) begin n_err++; $display("FAIL t1_bits: got %0d want 0", bits_shifted); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL t1_fd: got %b want 0", frame_done); end
      n_cmp++; if ({err_no_load, err_overshift, err_read_mid} !== 3'b000) begin
         n_err++; $display("FAIL t1_errs: got %b want 000", {err_no_load, err_overshift, err_read_mid});
      end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready: got %b want 1", cfg_ready); end
      sys_rst = 1'b0;
      tick;
      read = 1'b1; tick; read = 1'b0;
      n_cmp++; if (dout !== 1'b1) begin n_err++; $display("FAIL t1_first_bit: got %b want 1", dout); end
   endtask

   task automatic test_frame;
      fd_base = fd_count;
      read = 1'b1; tick; read = 1'b0;
      push_id(id_init);
      n_cmp++; if (bits_shifted !== 8'd0) begin n_err++; $display("FAIL t2_bits0: got %0d want 0", bits_shifted); end
      for (int k = 0; k < 57; k++) begin
         exp_bit = exp_q.pop_front();
         n_cmp++; if (dout !== exp_bit) begin n_err++; $display("FAIL t2_dout[%0d]: got %b want %b", k, dout, exp_bit); end
         shift = 1'b1; din = 1'b0; tick;
      end
      shift = 1'b0;
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL t2_fd_high: got %b want 1", frame_done); end
      n_cmp++; if (bits_shifted !== 8'd57) begin n_err++; $display("FAIL t2_bits: got %0d want 57", bits_shifted); end
      tick; tick;
      n_cmp++; if (fd_count - fd_base !== 1) begin n_err++; $display("FAIL t2_fd_pulses: got %0d want 1", fd_count - fd_base); end
      n_cmp++; if ({err_no_load, err_overshift, err_read_mid} !== 3'b000) begin
         n_err++; $display("FAIL t2_errs: got %b want 000", {err_no_load, err_overshift, err_read_mid});
      end
   endtask

   task automatic test_overshift;
      fd_base = fd_count;
      for (int i = 0; i < 57; i++) exp_q.push_back(1'b0);
      for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
      for (int k = 0; k < 60; k++) begin
         exp_bit = exp_q.pop_front();
         n_cmp++; if (dout !== exp_bit) begin n_err++; $display("FAIL t3_dout[%0d]: got %b want %b", k, dout, exp_bit); end
         shift = 1'b1; din = 1'b1; tick;
      end
      shift = 1'b0; din = 1'b0;
      n_cmp++; if (err_overshift !== 1'b1) begin n_err++; $display("FAIL t3_overshift: got %b want 1", err_overshift); end
      n_cmp++; if (bits_shifted !== 8'd117) begin n_err++; $display("FAIL t3_bits: got %0d want 117", bits_shifted); end
      tick;
      n_cmp++; if (fd_count !== fd_base) begin n_err++; $display("FAIL t3_fd_extra: got %0d want %0d", fd_count, fd_base); end
      err_clr = 1'b1; tick; err_clr = 1'b0;
      n_cmp++; if (err_overshift !== 1'b0) begin n_err++; $display("FAIL t3_clr: got %b want 0", err_overshift); end
   endtask

   task automatic test_no_load;
      sys_rst = 1'b1; #1 sys_rst = 1'b0;
      tick;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (dout !== 1'b0) begin n_err++; $display("FAIL t4_dout[%0d]: got %b want 0", k, dout); end
         shift = 1'b1; din = 1'b1; tick;
      end
      shift = 1'b0; din = 1'b0;
      n_cmp++; if (dout !== 1'b0) begin n_err++; $display("FAIL t4_dout_end: got %b want 0", dout); end
      n_cmp++; if (err_no_load !== 1'b1) begin n_err++; $display("FAIL t4_no_load: got %b want 1", err_no_load); end
      n_cmp++; if (bits_shifted !== 8'd5) begin n_err++; $display("FAIL t4_bits5: got %0d want 5", bits_shifted); end
      read = 1'b1; shift = 1'b1; tick; read = 1'b0; shift = 1'b0;
      n_cmp++; if (bits_shifted !== 8'd0) begin n_err++; $display("FAIL t4_rs_bits: got %0d want 0", bits_shifted); end
      n_cmp++; if (dout !== 1'b1) begin n_err++; $display("FAIL t4_rs_dout: got %b want 1", dout); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t4_rs_ready: got %b want 1", cfg_ready); end
      n_cmp++; if (err_read_mid !== 1'b0) begin n_err++; $display("FAIL t4_read_mid: got %b want 0", err_read_mid); end
   endtask

   task automatic test_cfg;
      fd_base = fd_count;
      shift = 1'b1; tick; shift = 1'b0;
      n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready_shift: got %b want 0", cfg_ready); end
      cfg_dna = id_new; cfg_load = 1'b1; tick; cfg_load = 1'b0;
      read = 1'b1; tick; read = 1'b0;
      n_cmp++; if (err_read_mid !== 1'b1) begin n_err++; $display("FAIL t5_read_mid: got %b want 1", err_read_mid); end
      push_id(id_init);
      for (int k = 0; k < 57; k++) begin
         exp_bit = exp_q.pop_front();
         n_cmp++; if (dout !== exp_bit) begin n_err++; $display("FAIL t5_old_dout[%0d]: got %b want %b", k, dout, exp_bit); end
         shift = 1'b1; tick;
      end
      shift = 1'b0;
      read = 1'b1; tick; read = 1'b0;
      n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t5_ready_loaded: got %b want 1", cfg_ready); end
      cfg_load = 1'b1; tick; cfg_load = 1'b0;
      read = 1'b1; tick; read = 1'b0;
      push_id(id_new);
      for (int k = 0; k < 57; k++) begin
         exp_bit = exp_q.pop_front();
         n_cmp++; if (dout !== exp_bit) begin n_err++; $display("FAIL t5_new_dout[%0d]: got %b want %b", k, dout, exp_bit); end
         shift = 1'b1; tick;
      end
      shift = 1'b0;
      tick;
      n_cmp++; if (fd_count - fd_base !== 2) begin n_err++; $display("FAIL t5_fd_pulses: got %0d want 2", fd_count - fd_base); end
   endtask

   task automatic test_reset_mid;
      sys_rst = 1'b1; #1 sys_rst = 1'b0;
      tick;
      cfg_dna = id_new; cfg_load = 1'b1; tick; cfg_load = 1'b0;
      read = 1'b1; tick; read = 1'b0;
      push_id(id_new);
      for (int k = 0; k < 30; k++) begin
         exp_bit = exp_q.pop_front();
         n_cmp++; if (dout !== exp_bit) begin n_err++; $display("FAIL t6_dout[%0d]: got %b want %b", k, dout, exp_bit); end
         shift = 1'b1; tick;
      end
      exp_q.delete();
      fd_base = fd_count;
      #2 sys_rst = 1'b1;
      #1;
      n_cmp++; if (bits_shifted !== 8'd0) begin n_err++; $display("FAIL t6_bits: got %0d want 0", bits_shifted); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready: got %b want 1", cfg_ready); end
      n_cmp++; if (dout !== 1'b0) begin n_err++; $display("FAIL t6_dout_rst: got %b want 0", dout); end
      #1 sys_rst = 1'b0;
      shift = 1'b0;
      tick; tick;
      n_cmp++; if (fd_count !== fd_base) begin n_err++; $display("FAIL t6_fd: got %0d want %0d", fd_count, fd_base); end
      read = 1'b1; tick; read = 1'b0;
      push_id(id_init);
      for (int k = 0; k < 57; k++) begin
         exp_bit = exp_q.pop_front();
         n_cmp++; if (dout !== exp_bit) begin n_err++; $display("FAIL t6_init_dout[%0d]: got %b want %b", k, dout, exp_bit); end
         shift = 1'b1; tick;
      end
      shift = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      tick;
      test_reset;
      test_frame;
      test_overshift;
      test_no_load;
      test_cfg;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
